// File: rtl/div_tick_ctrl_if.sv
// Config handshake bundle for div_tick_ctrl: divisor and tick budget over valid/ready.
interface div_tick_ctrl_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_count;

    modport master (output cfg_valid, cfg_div, cfg_count, input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_div, cfg_count, output cfg_ready);
endinterface

// File: rtl/div_tick_ctrl.sv
// Divide-by-N tick sequencer: free-running or budgeted single-cycle enable pulses.
// Optional DIV_TICK_DUTY50_EN adds a registered ~50% duty output div_out.
module div_tick_ctrl #(
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic           clk,
    input  logic           reset,
    div_tick_ctrl_if.slave cfg,
    input  logic           start,
    input  logic           stop,
    output logic           tick,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef DIV_TICK_DUTY50_EN
    ,
    output logic           div_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] phase_nxt;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] remaining;
    logic             cfg_acc;
    logic             cfg_ok;

    assign cfg.cfg_ready = (state == S_IDLE);
    assign cfg_acc       = cfg.cfg_valid && (state == S_IDLE);
    assign cfg_ok        = (cfg.cfg_div >= DIV_W'(2));
    assign phase_nxt     = (phase == div_reg - DIV_W'(1)) ? '0 : phase + DIV_W'(1);

    // Outputs are registered from the next-state values, so tick still equals
    // (state==RUN && phase==0) as seen from outside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            div_reg   <= DIV_W'(DEF_DIV);
            cnt_reg   <= '0;
            phase     <= '0;
            remaining <= '0;
            tick      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef DIV_TICK_DUTY50_EN
            div_out   <= 1'b0;
`endif
        end else begin
            tick    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef DIV_TICK_DUTY50_EN
            div_out <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (cfg_acc && cfg_ok) begin
                        div_reg <= cfg.cfg_div;
                        cnt_reg <= cfg.cfg_count;
                    end
                    err <= cfg_acc && !cfg_ok;
                    if (start) begin
                        state     <= S_RUN;
                        phase     <= '0;
                        remaining <= (cfg_acc && cfg_ok) ? cfg.cfg_count : cnt_reg;
                        tick      <= 1'b1;
                        busy      <= 1'b1;
`ifdef DIV_TICK_DUTY50_EN
                        div_out   <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (phase == '0 && remaining == CNT_W'(1)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        remaining <= '0;
                    end else begin
                        phase <= phase_nxt;
                        tick  <= (phase_nxt == '0);
                        busy  <= 1'b1;
`ifdef DIV_TICK_DUTY50_EN
                        div_out <= (phase_nxt < (div_reg >> 1));
`endif
                        if (phase == '0 && remaining != '0)
                            remaining <= remaining - CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Scoreboard bench for div_tick_ctrl: a run-window model schedules expected
// ticks/done/err/status per cycle; a negedge monitor pops and compares.
module tb_div_tick_ctrl;

    localparam int     DIV_W   = 8;
    localparam int     CNT_W   = 8;
    localparam int     DEF_DIV = 3;
    localparam longint INF     = 64'd1 << 40;

    logic clk;
    logic reset;
    logic start;
    logic stop;
    logic tick;
    logic busy;
    logic done;
    logic err;
`ifdef DIV_TICK_DUTY50_EN
    logic div_out;
`endif

    div_tick_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) cfg_if ();

    div_tick_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .cfg    (cfg_if),
        .start  (start),
        .stop   (stop),
        .tick   (tick),
        .busy   (busy),
        .done   (done),
        .err    (err)
`ifdef DIV_TICK_DUTY50_EN
        ,
        .div_out(div_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint c;
        bit     busy;
        bit     ready;
        bit     dout;
    } status_t;

    status_t sq[$];
    longint  tq[$];
    longint  dq[$];
    longint  eq[$];

    int checks = 0;
    int errors = 0;

    // Reference model: stored config plus the window of cycles the DUT is running.
    int     m_div = DEF_DIV;
    int     m_cnt = 0;
    longint run_from = 0;
    longint run_last = -1;
    longint run_n = DEF_DIV;
    longint done_cyc = -1;
    bit     armed = 0;
    longint check_from = INF;

    function automatic bit in_run(longint t);
        return (t >= run_from) && (t <= run_last);
    endfunction

    function automatic void chk(string name, logic act, bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%0b", name, cyc, act, exp);
        end
    endfunction

    task automatic step(input bit r, input bit v, input int d, input int n,
                        input bit st, input bit sp);
        longint  c;
        longint  t;
        bit      idle_now;
        bit      inr;
        status_t s;
        @(posedge clk);
        #1;
        reset            = r;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_div   = DIV_W'(d);
        cfg_if.cfg_count = CNT_W'(n);
        start            = st;
        stop             = sp;
        c = cyc;
        if (r) begin
            m_div    = DEF_DIV;
            m_cnt    = 0;
            run_from = 0;
            run_last = -1;
            done_cyc = -1;
            if (!armed) begin
                armed      = 1;
                check_from = c + 1;
            end
        end else begin
            idle_now = !in_run(c) && (c != done_cyc);
            if (idle_now && v) begin
                if (d >= 2) begin
                    m_div = d;
                    m_cnt = n;
                end else begin
                    eq.push_back(c + 1);
                end
            end
            if (idle_now && st) begin
                run_from = c + 1;
                run_n    = m_div;
                if (m_cnt == 0) begin
                    run_last = INF;
                    done_cyc = -1;
                end else begin
                    run_last = c + 1 + longint'(m_cnt - 1) * m_div;
                    done_cyc = run_last + 1;
                end
            end else if (in_run(c) && sp) begin
                run_last = c;
                done_cyc = -1;
            end
        end
        if (armed) begin
            t   = c + 1;
            inr = in_run(t);
            if (inr && ((t - run_from) % run_n == 0)) tq.push_back(t);
            if (t == done_cyc) dq.push_back(t);
            s.c     = t;
            s.busy  = inr;
            s.ready = !inr && (t != done_cyc);
            s.dout  = inr && (((t - run_from) % run_n) < (run_n / 2));
            sq.push_back(s);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int d, input int n);
        step(0, 1, d, n, 0, 0);
    endtask

    task automatic go();
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic halt();
        step(0, 0, 0, 0, 0, 1);
    endtask

    bit      e_tick;
    bit      e_done;
    bit      e_err;
    status_t s_mon;

    always @(negedge clk) begin
        if (armed && cyc >= check_from) begin
            e_tick = (tq.size() > 0) && (tq[0] == cyc);
            if (e_tick) void'(tq.pop_front());
            chk("tick", tick, e_tick);
            e_done = (dq.size() > 0) && (dq[0] == cyc);
            if (e_done) void'(dq.pop_front());
            chk("done", done, e_done);
            e_err = (eq.size() > 0) && (eq[0] == cyc);
            if (e_err) void'(eq.pop_front());
            chk("err", err, e_err);
            if (sq.size() > 0 && sq[0].c == cyc) begin
                s_mon = sq.pop_front();
                chk("busy", busy, s_mon.busy);
                chk("cfg_ready", cfg_if.cfg_ready, s_mon.ready);
`ifdef DIV_TICK_DUTY50_EN
                chk("div_out", div_out, s_mon.dout);
`endif
            end else begin
                checks++;
                errors++;
                $display("FAIL status_missing cyc=%0d actual=none required=entry", cyc);
            end
        end
    end

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        stop             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_count = '0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // free run, N=3
        cfg(3, 0); go(); idle(12); halt(); idle(2);
        // budget 4, N=5
        cfg(5, 4); go(); idle(20);
        // rejected divisor after reset keeps DEF_DIV
        step(1, 0, 0, 0, 0, 0); idle(1);
        cfg(1, 0); idle(2); go(); idle(10); halt(); idle(2);
        // stop on the 2nd tick
        cfg(4, 0); go(); idle(4); halt(); idle(6);
        // reset mid-run, then restart on DEF_DIV
        cfg(6, 0); go(); idle(7); step(1, 0, 0, 0, 0, 0); idle(1); go(); idle(9); halt(); idle(2);
        // config and start during RUN are ignored
        cfg(4, 0); go(); idle(2); step(0, 1, 9, 0, 1, 0); idle(8); halt(); idle(2);
        // config accepted in the start cycle, then rejected config with start
        step(0, 1, 7, 2, 1, 0); idle(16);
        step(0, 1, 0, 5, 1, 0); idle(16);
        // budget of one, and stop on the final budgeted tick
        cfg(2, 1); go(); idle(4);
        cfg(3, 2); go(); idle(3); halt(); idle(3);
        // maximum divisor, brief run
        cfg(255, 1); go(); idle(4); halt(); idle(3);

        for (int i = 0; i < 3000; i++) begin
            int  sel;
            int  d;
            sel = $urandom_range(0, 9);
            if (sel == 0)      d = $urandom_range(0, 1);
            else if (sel == 9) d = $urandom_range(200, 255);
            else               d = $urandom_range(2, 8);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, d,
                 $urandom_range(0, 5), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 29) == 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
